// File: rtl/foreground_frame_sequencer_pkg.sv
// Shared types for the foreground frame sequencer and its per-pixel comparator.
// Contents: pixel_t {r,g,b}, the sequencer state enum, the default comparator
// threshold and a pixel-count helper for frame sizing.
package fg_pkg;

  localparam int unsigned DEFAULT_THRESHOLD = 25;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  function automatic int unsigned num_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/foreground_frame_sequencer_comparator.sv
// Per-pixel foreground comparator: a pixel is foreground when any channel's
// absolute difference to the background is >= THRESHOLD. Purely combinational.
// Ports: cur, bg (pixel_t) in; is_fg_c out.
module foreground_frame_sequencer_comparator
  import fg_pkg::*;
#(
  parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
  input  pixel_t cur,
  input  pixel_t bg,
  output logic   is_fg_c
);

  localparam logic [8:0] THR_W = 9'(THRESHOLD);

  // 9-bit signed subtraction spans -255..255, so neither the difference nor its negation overflows.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 9'(-d) : 9'(d);
  endfunction

  always_comb begin
    is_fg_c = (abs_diff(cur.r, bg.r) >= THR_W) ||
              (abs_diff(cur.g, bg.g) >= THR_W) ||
              (abs_diff(cur.b, bg.b) >= THR_W);
  end

endmodule

// File: rtl/foreground_frame_sequencer.sv
// Frame-level sequencer: on start, scans the current-frame and background RAMs
// one pixel per clock, writes a 1-bit foreground mask, counts foreground pixels
// and reports fg_count/motion with a done pulse at frame end.
// Ports: clk, reset (async, active-high), start; busy, done; rd_addr with
// cur_pixel/bg_pixel read data (1-cycle latency); mask_we/mask_addr/mask_data;
// bg_we/bg_waddr/bg_wdata; fg_count, motion.
// Build option: define BACKGROUND_UPDATE_EN to write non-foreground current
// pixels back into the background RAM; otherwise the bg_* outputs are tied to 0.
module foreground_frame_sequencer
  import fg_pkg::*;
#(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned THRESHOLD  = DEFAULT_THRESHOLD,
  parameter int unsigned MOTION_MIN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       cur_pixel,
  input  logic [23:0]       bg_pixel,
  output logic              mask_we,
  output logic [ADDR_W-1:0] mask_addr,
  output logic              mask_data,
  output logic              bg_we,
  output logic [ADDR_W-1:0] bg_waddr,
  output logic [23:0]       bg_wdata,
  output logic [ADDR_W:0]   fg_count,
  output logic              motion
);

  localparam int unsigned       NPIX       = num_pixels(WIDTH, HEIGHT);
  localparam int unsigned       CNT_W      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  MOTION_THR = CNT_W'(MOTION_MIN);

  fsm_t              state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pix_vld_q, pix_vld_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              mask_we_q, mask_we_d;
  logic [ADDR_W-1:0] mask_addr_q, mask_addr_d;
  logic              mask_data_q, mask_data_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  fg_count_q, fg_count_d;
  logic              motion_q, motion_d;
  logic              is_fg_c;

  foreground_frame_sequencer_comparator #(
    .THRESHOLD(THRESHOLD)
  ) u_cmp (
    .cur     (pixel_t'(cur_pixel)),
    .bg      (pixel_t'(bg_pixel)),
    .is_fg_c (is_fg_c)
  );

  // Next-state, address counter, pixel pipeline and accumulator.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    drain_d     = drain_q;
    acc_d       = acc_q;
    fg_count_d  = fg_count_q;
    motion_d    = motion_q;
    // Address issued this cycle has its RAM data next cycle; result is registered after that.
    pix_vld_d   = (state_q == SCAN);
    pix_addr_d  = rd_addr_q;
    mask_we_d   = pix_vld_q;
    mask_addr_d = pix_addr_q;
    mask_data_d = pix_vld_q & is_fg_c;

    if (mask_we_q && mask_data_q) begin
      acc_d = acc_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          rd_addr_d = '0;
          acc_d     = '0;
        end
      end
      SCAN: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        // Second drain cycle carries the final mask write; fold it into the published count.
        if (drain_q) begin
          state_d    = DONE;
          fg_count_d = acc_d;
          motion_d   = (acc_d >= MOTION_THR);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SCAN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_vld_q   <= 1'b0;
      pix_addr_q  <= '0;
      mask_we_q   <= 1'b0;
      mask_addr_q <= '0;
      mask_data_q <= 1'b0;
      acc_q       <= '0;
      fg_count_q  <= '0;
      motion_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_vld_q   <= pix_vld_d;
      pix_addr_q  <= pix_addr_d;
      mask_we_q   <= mask_we_d;
      mask_addr_q <= mask_addr_d;
      mask_data_q <= mask_data_d;
      acc_q       <= acc_d;
      fg_count_q  <= fg_count_d;
      motion_q    <= motion_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign mask_we   = mask_we_q;
  assign mask_addr = mask_addr_q;
  assign mask_data = mask_data_q;
  assign fg_count  = fg_count_q;
  assign motion    = motion_q;

`ifdef BACKGROUND_UPDATE_EN
  logic              bg_we_q, bg_we_d;
  logic [ADDR_W-1:0] bg_waddr_q, bg_waddr_d;
  logic [23:0]       bg_wdata_q, bg_wdata_d;

  // Background write rides alongside the mask write; reads are always ahead of it.
  always_comb begin
    bg_we_d    = pix_vld_q & ~is_fg_c;
    bg_waddr_d = pix_addr_q;
    bg_wdata_d = cur_pixel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg_we_q    <= 1'b0;
      bg_waddr_q <= '0;
      bg_wdata_q <= '0;
    end else begin
      bg_we_q    <= bg_we_d;
      bg_waddr_q <= bg_waddr_d;
      bg_wdata_q <= bg_wdata_d;
    end
  end

  assign bg_we    = bg_we_q;
  assign bg_waddr = bg_waddr_q;
  assign bg_wdata = bg_wdata_q;
`else
  assign bg_we    = 1'b0;
  assign bg_waddr = '0;
  assign bg_wdata = '0;
`endif

endmodule
